// File: rtl/ddr_wr_burst_ctrl_if.sv
// Bundles the user input stream, the datamover command channel and the
// datamover write-data channel of ddr_wr_burst_ctrl.
interface ddr_wr_burst_ctrl_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
);

  // user stream into the FIFO
  logic                  in_vld;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  // command channel
  logic                  start;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [LEN_WIDTH-1:0]  wdata_len;

  // write-data channel
  logic                  wdata_vld;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wready;

  // master: the burst controller
  modport master (
    input  in_vld, in_data, cmd_ready, wready,
    output in_ready, start, waddr, wdata_len, wdata_vld, wdata
  );

  // slave: user source plus datamover
  modport slave (
    output in_vld, in_data, cmd_ready, wready,
    input  in_ready, start, waddr, wdata_len, wdata_vld, wdata
  );

endinterface

// File: rtl/ddr_wr_burst_ctrl.sv
// Buffers a user word stream in a FWFT FIFO and, once a full burst is held,
// issues one write command and streams that burst into a DDR ring region.
module ddr_wr_burst_ctrl #(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    LEN_WIDTH    = 16,
  parameter int                    BURST_BYTES  = 4096,
  parameter int                    FIFO_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_WIDTH-1:0] REGION_BYTES = 32'h0100_0000
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  ddr_wr_burst_ctrl_if.master           bus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   burst_cnt,
  output logic                          wrap_pulse,
  output logic                          overflow
);

  localparam int BPW         = DATA_WIDTH / 8;
  localparam int BURST_WORDS = BURST_BYTES / BPW;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]        LVL_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]        DEPTH_LVL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]        BURST_LVL = (PTR_W+1)'(BURST_WORDS);
  localparam logic [15:0]           LAST_WORD = 16'(BURST_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BURST_INC = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] RING_END  = BASE_ADDR + REGION_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    XFER,
    GAP
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  push, pop, fifo_empty;
  logic [15:0]           word_cnt;
  logic                  gap_cnt;
  logic                  burst_done;
  logic [ADDR_WIDTH-1:0] next_addr;

  // ------------------------------------------------------------------
  // FIFO
  // ------------------------------------------------------------------
  assign bus.in_ready = (fifo_level != DEPTH_LVL);
  assign fifo_empty   = (fifo_level == '0);
  assign push         = bus.in_vld & bus.in_ready;
  assign pop          = bus.wdata_vld & bus.wready;

  // NOTE: the storage array is deliberately not reset; clearing pointers and
  // level is enough to flush it, and it keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // in the block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      if (bus.in_vld && !bus.in_ready) overflow <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Burst FSM
  // ------------------------------------------------------------------
  assign burst_done = pop & (word_cnt == LAST_WORD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt gets its default before the case so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en && (fifo_level >= BURST_LVL)) state_nxt = CMD;
      CMD:     if (bus.cmd_ready) state_nxt = XFER;
      XFER:    if (burst_done) state_nxt = GAP;
      GAP:     if (gap_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs; the data channel is only ever valid inside XFER
  assign busy          = (state != IDLE);
  assign bus.start     = (state == CMD);
  assign bus.wdata_vld = (state == XFER) && !fifo_empty;
  assign bus.wdata     = bus.wdata_vld ? mem[rd_ptr] : '0;
  assign bus.wdata_len = LEN_WIDTH'(BURST_BYTES);

  // ------------------------------------------------------------------
  // Word/gap counters, ring address and burst statistics
  // ------------------------------------------------------------------
  assign next_addr = bus.waddr + BURST_INC;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_cnt   <= '0;
      gap_cnt    <= 1'b0;
      bus.waddr  <= BASE_ADDR;
      burst_cnt  <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      gap_cnt    <= (state == GAP) ? ~gap_cnt : 1'b0;

      if (pop) begin
        word_cnt <= burst_done ? '0 : word_cnt + 16'd1;
      end

      // GAP entry: waddr only moves here, so it is stable across CMD
      if (burst_done) begin
        burst_cnt <= burst_cnt + 16'd1;
        if (next_addr == RING_END) begin
          bus.waddr  <= BASE_ADDR;
          wrap_pulse <= 1'b1;
        end else begin
          bus.waddr  <= next_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Self-checking bench for ddr_wr_burst_ctrl: 64-byte bursts of 8 words,
// 256-byte ring at 0x1000, 16-word FIFO.
module tb_ddr_wr_burst_ctrl;

  localparam int          DW     = 64;
  localparam int          AW     = 32;
  localparam int          LW     = 16;
  localparam int          BB     = 64;
  localparam int          FD     = 16;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] REGION = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        busy, wrap_pulse, overflow;
  logic [4:0]  fifo_level;
  logic [15:0] burst_cnt;

  ddr_wr_burst_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  ddr_wr_burst_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .LEN_WIDTH   (LW),
    .BURST_BYTES (BB),
    .FIFO_DEPTH  (FD),
    .BASE_ADDR   (BASE),
    .REGION_BYTES(REGION)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .bus       (bus),
    .busy      (busy),
    .fifo_level(fifo_level),
    .burst_cnt (burst_cnt),
    .wrap_pulse(wrap_pulse),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard and driver state
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr = BASE;
  int          next_id = 0;
  int          push_left = 0;
  logic        push_blind = 1'b0;
  logic        wr_toggle = 1'b0;
  logic        wr_phase = 1'b1;
  int          cmd_hold = 0;
  int          cmd_wait = 0;
  int          pops_seen = 0;
  int          start_cycles = 0;
  int          wraps_seen = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_wdata = '0;

  typedef struct {
    int          n_words;
    logic        toggle;
    int          cmd_hold;
    int          exp_bursts;
    int          exp_level;
    int          exp_starts;
    logic [31:0] exp_off;
    int          exp_wraps;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [63:0] word(input int id);
    return {16'hBEEF, 16'(id), 32'(id * 7 + 3)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"},      64'(bus.start),     64'd0);
    check({tag, "_wdata_vld"},  64'(bus.wdata_vld), 64'd0);
    check({tag, "_busy"},       64'(busy),          64'd0);
    check({tag, "_wrap_pulse"}, 64'(wrap_pulse),    64'd0);
    check({tag, "_overflow"},   64'(overflow),      64'd0);
    check({tag, "_burst_cnt"},  64'(burst_cnt),     64'd0);
    check({tag, "_fifo_level"}, 64'(fifo_level),    64'd0);
    check({tag, "_in_ready"},   64'(bus.in_ready),  64'd1);
    check({tag, "_waddr"},      64'(bus.waddr),     64'(BASE));
    check({tag, "_wdata_len"},  64'(bus.wdata_len), 64'(BB));
    check({tag, "_wdata"},      bus.wdata,          64'd0);
  endtask

  // One clock cycle: entered at posedge+1, drives inputs, observes at
  // posedge+4, then returns at the next posedge+1.
  task automatic step();
    if (push_left > 0 && (push_blind || bus.in_ready)) begin
      bus.in_vld  = 1'b1;
      bus.in_data = word(next_id);
      if (bus.in_ready) exp_q.push_back(word(next_id));
      next_id++;
      push_left--;
    end else begin
      bus.in_vld = 1'b0;
    end
    bus.wready = wr_toggle ? wr_phase : 1'b1;
    wr_phase   = ~wr_phase;
    if (bus.start) begin
      bus.cmd_ready = (cmd_wait >= cmd_hold);
      cmd_wait      = bus.cmd_ready ? 0 : cmd_wait + 1;
    end else begin
      bus.cmd_ready = 1'b0;
      cmd_wait      = 0;
    end

    #3;
    if (prev_stall) begin
      check("hold_vld",  64'(bus.wdata_vld), 64'd1);
      check("hold_data", bus.wdata, prev_wdata);
    end
    if (bus.wdata_vld && bus.wready) begin
      pops_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: got %0h expected no word", bus.wdata);
      end else begin
        check("wdata", bus.wdata, exp_q.pop_front());
      end
    end
    prev_stall = bus.wdata_vld && !bus.wready;
    prev_wdata = bus.wdata;
    if (bus.start) start_cycles++;
    if (bus.start && bus.cmd_ready) begin
      check("cmd_waddr",     64'(bus.waddr),     64'(exp_addr));
      check("cmd_wdata_len", 64'(bus.wdata_len), 64'(BB));
      exp_addr = (exp_addr + 32'(BB) == BASE + REGION) ? BASE : exp_addr + 32'(BB);
    end
    if (wrap_pulse) begin
      wraps_seen++;
      check("wrap_waddr", 64'(bus.waddr), 64'(BASE));
    end

    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input int n_push, input int target, input string tag);
    int n;
    n = 0;
    push_left  = n_push;
    push_blind = 1'b0;
    while (n < 400 && !(push_left == 0 && burst_cnt == 16'(target) && !busy)) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got burst_cnt %0d expected %0d", tag, burst_cnt, target);
    end
    repeat (6) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{n_words: 8,  toggle: 1'b0, cmd_hold: 0, exp_bursts: 2, exp_level: 0,
                exp_starts: 1, exp_off: 32'd128, exp_wraps: 0};
    vecs[1] = '{n_words: 8,  toggle: 1'b1, cmd_hold: 5, exp_bursts: 3, exp_level: 0,
                exp_starts: 6, exp_off: 32'd192, exp_wraps: 0};
    vecs[2] = '{n_words: 12, toggle: 1'b0, cmd_hold: 0, exp_bursts: 4, exp_level: 4,
                exp_starts: 1, exp_off: 32'd0,   exp_wraps: 1};
    vecs[3] = '{n_words: 4,  toggle: 1'b1, cmd_hold: 0, exp_bursts: 5, exp_level: 0,
                exp_starts: 1, exp_off: 32'd64,  exp_wraps: 0};
    vecs[4] = '{n_words: 16, toggle: 1'b1, cmd_hold: 2, exp_bursts: 7, exp_level: 0,
                exp_starts: 6, exp_off: 32'd192, exp_wraps: 0};

    bus.in_vld    = 1'b0;
    bus.in_data   = '0;
    bus.cmd_ready = 1'b0;
    bus.wready    = 1'b1;

    // reset state
    #12;
    check_reset_values("rst");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    en   = 1'b1;

    // threshold and start/data latency
    push_left = 7;
    repeat (10) step();
    check("thr7_start", 64'(bus.start),  64'd0);
    check("thr7_level", 64'(fifo_level), 64'd7);
    check("thr7_busy",  64'(busy),       64'd0);
    push_left = 1;
    step();
    check("thr8_start_n1", 64'(bus.start),  64'd0);
    check("thr8_level_n1", 64'(fifo_level), 64'd8);
    step();
    check("thr8_start_n2", 64'(bus.start), 64'd1);
    step();
    check("first_data_lat", 64'(bus.wdata_vld), 64'd1);
    run_until(0, 1, "basic");
    check("basic_burst_cnt", 64'(burst_cnt),  64'd1);
    check("basic_waddr",     64'(bus.waddr),  64'(BASE + 32'd64));
    check("basic_level",     64'(fifo_level), 64'd0);

    // table-driven bursts: backpressure, command hold, wrap
    for (int i = 0; i < 5; i++) begin
      int s0, w0;
      s0        = start_cycles;
      w0        = wraps_seen;
      wr_toggle = vecs[i].toggle;
      cmd_hold  = vecs[i].cmd_hold;
      run_until(vecs[i].n_words, vecs[i].exp_bursts, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_burst_cnt", i), 64'(burst_cnt),  64'(vecs[i].exp_bursts));
      check($sformatf("vec%0d_level", i),     64'(fifo_level), 64'(vecs[i].exp_level));
      check($sformatf("vec%0d_waddr", i),     64'(bus.waddr),  64'(BASE + vecs[i].exp_off));
      check($sformatf("vec%0d_starts", i),    64'(start_cycles - s0), 64'(vecs[i].exp_starts));
      check($sformatf("vec%0d_wraps", i),     64'(wraps_seen - w0),   64'(vecs[i].exp_wraps));
      check($sformatf("vec%0d_sb_resid", i),  64'(exp_q.size()),      64'(fifo_level));
    end
    wr_toggle = 1'b0;
    cmd_hold  = 0;
    check("ovf_pre", 64'(overflow), 64'd0);

    // overflow with en low
    en         = 1'b0;
    push_left  = 20;
    push_blind = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 14) check("ovf_ready_15", 64'(bus.in_ready), 64'd1);
      if (i == 15) check("ovf_ready_16", 64'(bus.in_ready), 64'd0);
    end
    push_blind = 1'b0;
    check("ovf_in_ready",  64'(bus.in_ready), 64'd0);
    check("ovf_flag",      64'(overflow),     64'd1);
    check("ovf_level",     64'(fifo_level),   64'd16);
    check("ovf_busy",      64'(busy),         64'd0);
    check("ovf_burst_cnt", 64'(burst_cnt),    64'd7);

    // drain: en drops after the first start; that burst still completes
    en = 1'b1;
    begin
      int n;
      n = 0;
      while (n < 20 && !bus.start) begin
        step();
        n++;
      end
      check("drain_start_seen", 64'(bus.start), 64'd1);
    end
    en = 1'b0;
    begin
      int w0;
      w0 = wraps_seen;
      run_until(0, 8, "drain1");
      check("drain1_burst_cnt", 64'(burst_cnt),      64'd8);
      check("drain1_level",     64'(fifo_level),     64'd8);
      check("drain1_busy",      64'(busy),           64'd0);
      check("drain1_wraps",     64'(wraps_seen - w0), 64'd1);
      check("drain1_waddr",     64'(bus.waddr),      64'(BASE));
    end
    en = 1'b1;
    run_until(0, 9, "drain2");
    check("drain2_burst_cnt", 64'(burst_cnt),  64'd9);
    check("drain2_level",     64'(fifo_level), 64'd0);
    check("drain2_waddr",     64'(bus.waddr),  64'(BASE + 32'd64));
    check("drain2_ovf",       64'(overflow),   64'd1);

    // asynchronous reset in mid-XFER after three words
    begin
      int p0, n;
      p0        = pops_seen;
      n         = 0;
      push_left = 8;
      while (n < 60 && pops_seen - p0 < 3) begin
        step();
        n++;
      end
      check("mid_pops", 64'(pops_seen - p0), 64'd3);
    end
    bus.in_vld = 1'b0;
    push_left  = 0;
    #1;
    rstn = 1'b0;
    #1;
    check_reset_values("async");
    exp_q.delete();
    exp_addr   = BASE;
    prev_stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    run_until(8, 1, "post_rst");
    check("post_rst_burst_cnt", 64'(burst_cnt),  64'd1);
    check("post_rst_waddr",     64'(bus.waddr),  64'(BASE + 32'd64));
    check("post_rst_level",     64'(fifo_level), 64'd0);
    check("post_rst_sb_empty",  64'(exp_q.size()), 64'(fifo_level));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
